// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the sample-loader state encoding.
package fft_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    COMPUTE
  } loader_state_t;

endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample stream (valid/ready/last) plus the AXI-side RAM write port of the loader.
interface fft_sample_loader_if #(
  parameter int unsigned ADDR_W = fft_pkg::ADDR_W
);

  logic [fft_pkg::DATA_W-1:0] s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_last;
  logic [ADDR_W-1:0]          ram_adr;
  logic [fft_pkg::DATA_W-1:0] ram_data;
  logic                       ram_write;

  // master: sample source and RAM observer; slave: the loader itself
  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, ram_adr, ram_data, ram_write
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, ram_adr, ram_data, ram_write
  );

endinterface

// File: rtl/fft_bitrev.sv
// Combinational LOG2N-bit index reverser used for decimation-in-time pre-ordering.
module fft_bitrev #(
  parameter int unsigned LOG2N = 12
) (
  input  logic [LOG2N-1:0] idx,
  output logic [LOG2N-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      rev[i] = idx[LOG2N-1-i];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// FFT input stage: loads N-sample frames into the sample RAM, then hands the RAM to the FFT.
// Define FFT_LOADER_BITREV_EN to write frames in bit-reversed address order.
module fft_sample_loader #(
  parameter int unsigned LOG2N  = 12,
  parameter int unsigned ADDR_W = fft_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_sample_loader_if.slave   bus,
  output logic                 mode,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt
);

  import fft_pkg::*;

  localparam logic [LOG2N-1:0] IDX_LAST = '1;

  loader_state_t       state_q, state_d;
  logic [LOG2N-1:0]    idx_q, idx_d;
  logic [LOG2N-1:0]    map_idx;
  logic                accept;
  logic                last_idx;

  logic                s_ready_q;
  logic [ADDR_W-1:0]   ram_adr_q;
  logic [DATA_W-1:0]   ram_data_q;
  logic                ram_write_q;
  logic                mode_q;
  logic                fft_start_q;
  logic                frame_err_q;
  logic [15:0]         frame_cnt_q;

`ifdef FFT_LOADER_BITREV_EN
  fft_bitrev #(.LOG2N(LOG2N)) u_bitrev (
    .idx (idx_q),
    .rev (map_idx)
  );
`else
  assign map_idx = idx_q;
`endif

  // s_ready_q mirrors state_q == LOAD, so accept never depends on a combinational input path
  assign accept   = bus.s_valid && s_ready_q;
  assign last_idx = (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (last_idx) begin
            state_d = DRAIN;
            idx_d   = '0;
          end else if (bus.s_last) begin
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DRAIN:   state_d = COMPUTE;
      COMPUTE: if (fft_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      s_ready_q   <= 1'b1;
      ram_adr_q   <= '0;
      ram_data_q  <= '0;
      ram_write_q <= 1'b0;
      mode_q      <= 1'b0;
      fft_start_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_ready_q   <= (state_d == LOAD);
      mode_q      <= (state_d == COMPUTE);
      ram_write_q <= accept;
      if (accept) begin
        ram_adr_q  <= ADDR_W'(map_idx);
        ram_data_q <= bus.s_data;
      end
      // s_last must coincide exactly with the N-th beat
      frame_err_q <= accept && (bus.s_last != last_idx);
      fft_start_q <= (state_q == DRAIN);
      if (state_q == DRAIN) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.ram_adr   = ram_adr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_write = ram_write_q;
  assign mode          = mode_q;
  assign fft_start     = fft_start_q;
  assign frame_err     = frame_err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader at LOG2N = 4; address order follows FFT_LOADER_BITREV_EN.
module tb_fft_sample_loader;

  localparam int unsigned LOG2N  = 4;
  localparam int unsigned ADDR_W = 12;

  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [15:0]       data;
    logic              err;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode, fft_start, fft_done, frame_err;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t         sbq[$];
  wr_t         mon_e;
  logic [3:0]  m_idx = '0;

  fft_sample_loader_if #(.ADDR_W(ADDR_W)) bus ();

  fft_sample_loader #(.LOG2N(LOG2N), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mode      (mode),
    .fft_start (fft_start),
    .fft_done  (fft_done),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_adr(input logic [3:0] i);
`ifdef FFT_LOADER_BITREV_EN
    return {8'h00, i[0], i[1], i[2], i[3]};
`else
    return {8'h00, i};
`endif
  endfunction

  // Drive one beat and wait (bounded) for the edge that accepts it
  task automatic send(input logic [15:0] d, input logic last);
    logic r;
    logic ok;
    wr_t  e;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int k = 0; k < 64; k++) begin
      r = bus.s_ready;
      @(posedge clk);
      #1;
      if (r === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e.adr  = exp_adr(m_idx);
      e.data = d;
      e.err  = (last != (m_idx == 4'hF));
      sbq.push_back(e);
      m_idx = (last || m_idx == 4'hF) ? 4'h0 : m_idx + 4'h1;
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic done_pulse();
    fft_done = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"},   bus.s_ready,   1);
    chk({tag, "_ram_adr"},   bus.ram_adr,   0);
    chk({tag, "_ram_data"},  bus.ram_data,  0);
    chk({tag, "_ram_write"}, bus.ram_write, 0);
    chk({tag, "_mode"},      mode,          0);
    chk({tag, "_fft_start"}, fft_start,     0);
    chk({tag, "_frame_err"}, frame_err,     0);
    chk({tag, "_frame_cnt"}, frame_cnt,     0);
  endtask

  // Scoreboard: every write must match the oldest accepted beat
  always @(negedge clk) begin
    if (bus.ram_write === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("wr_adr",  32'(bus.ram_adr),  32'(mon_e.adr));
        chk("wr_data", 32'(bus.ram_data), 32'(mon_e.data));
        chk("wr_err",  32'(frame_err),    32'(mon_e.err));
      end
    end else begin
      chk("idle_write", bus.ram_write, 0);
      chk("idle_err",   frame_err,     0);
    end
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    fft_done    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    // Back-to-back frame
    for (int i = 0; i < 16; i++) send(16'(i), i == 15);
    chk("drain_s_ready", bus.s_ready, 0);
    chk("drain_mode",    mode,        0);
    chk("drain_start",   fft_start,   0);
    @(posedge clk); #1;
    chk("f1_mode",  mode,      1);
    chk("f1_start", fft_start, 1);
    chk("f1_cnt",   frame_cnt, 1);

    // Backpressure: valid held through COMPUTE
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hDEAD;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_s_ready", bus.s_ready, 0);
      chk("bp_start",   fft_start,   0);
      chk("bp_mode",    mode,        1);
    end
    done_pulse();
    chk("done_s_ready", bus.s_ready,   1);
    chk("done_mode",    mode,          0);
    chk("done_nowrite", bus.ram_write, 0);

    // Early s_last on beat 5: discarded partial frame
    for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i), i == 5);
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("early_mode",    mode,        0);
    chk("early_s_ready", bus.s_ready, 1);
    chk("early_cnt",     frame_cnt,   1);

    // Full frame; fft_done pulsed in LOAD and in DRAIN is ignored
    for (int i = 0; i < 16; i++) begin
      if (i == 3) fft_done = 1'b1;
      send(16'h0200 + 16'(i), i == 15);
      fft_done = 1'b0;
    end
    bus.s_valid = 1'b0;
    done_pulse();
    chk("f2_mode",  mode,      1);
    chk("f2_start", fft_start, 1);
    chk("f2_cnt",   frame_cnt, 2);
    @(posedge clk); #1;
    chk("f2_hold_mode", mode, 1);
    done_pulse();
    chk("f2_back_load", bus.s_ready, 1);

    // Frame whose 16th beat lacks s_last: error flagged but frame used
    for (int i = 0; i < 16; i++) send(16'h0300 + 16'(i), 1'b0);
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    chk("f3_start", fft_start, 1);
    chk("f3_cnt",   frame_cnt, 3);
    done_pulse();

    // Reset after 7 beats
    for (int i = 0; i < 7; i++) send(16'h0400 + 16'(i), 1'b0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    m_idx = '0;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_sbq_empty", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send(16'h0500 + 16'(i), i == 15);
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    chk("f4_start", fft_start, 1);
    chk("f4_cnt",   frame_cnt, 1);
    done_pulse();
    repeat (2) @(posedge clk);
    #1;
    chk("final_sbq_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Input stage of the FFT datapath. Accepts a stream of 16-bit time-domain samples over a valid/ready handshake and writes each frame of N samples into the sample RAM through its AXI-side write port, in bit-reversed address order. When a frame is complete, it switches the RAM to circuit mode, starts the FFT engine, and holds off input until the engine reports completion.

## Interface
Parameters:
- LOG2N, default 12: log2 of the frame length N. Legal range is 2..12.
- ADDR_W, default 12: RAM address width. Must satisfy ADDR_W ≥ LOG2N.

Ports:
- clk, input, 1: the single clock. Everything is sampled on the rising edge.
- rst, input, 1: reset. Asynchronous and active-high.
- s_data, input, 16: sample value.
- s_valid, input, 1: s_data is valid this cycle.
- s_ready, output, 1: the loader can accept a sample this cycle.
- s_last, input, 1: marks the final sample of a frame.
- ram_adr, output, ADDR_W: write address, driven to the RAM's axi_adr_in.
- ram_data, output, 16: write data, driven to the RAM's axi_data_in.
- ram_write, output, 1: write strobe, driven to the RAM's axi_write.
- mode, output, 1: RAM owner select. 0 = loader/AXI side, 1 = FFT circuit.
- fft_start, output, 1: one-cycle pulse that starts the FFT engine.
- fft_done, input, 1: one-cycle pulse from the FFT engine when it finishes.
- frame_err, output, 1: one-cycle pulse when a framing error is detected.
- frame_cnt, output, 16: count of frames handed to the FFT. Wraps modulo 2^16.

## Operation
- State machine: LOAD, DRAIN, COMPUTE. Reset enters LOAD with the sample index cleared to 0.
- LOAD:
  - s_ready = 1 and mode = 0.
  - A beat is accepted when s_valid && s_ready.
  - Each accepted beat registers ram_adr = addr_map(idx), zero-extended to ADDR_W; ram_data = s_data; ram_write = 1. Then idx increments.
- Accepting the beat with idx = N-1 moves to DRAIN. If s_last is 0 on that beat, frame_err pulses but the frame is still used.
- If s_last = 1 on a beat with idx < N-1:
  - That beat is still written.
  - frame_err pulses.
  - idx returns to 0 and the machine stays in LOAD. The partial frame is discarded and is not counted.
- DRAIN: lasts exactly one cycle, with s_ready = 0 and mode = 0. This lets the final write land in RAM while the RAM is still in AXI mode. The next state is COMPUTE.
- COMPUTE:
  - mode = 1 and s_ready = 0.
  - fft_start pulses in the first COMPUTE cycle, and frame_cnt increments in that same cycle.
  - On fft_done: return to LOAD with idx = 0 and mode = 0 from the next cycle.
- fft_done is ignored outside COMPUTE.
- ram_write is 0 in every cycle that has no accepted beat. ram_adr and ram_data hold their last values.
- Asserting rst mid-frame or mid-compute:
  - Aborts immediately to LOAD with mode = 0.
  - Nothing is written to RAM after the reset edge.
  - The partial frame is lost and frame_cnt is cleared.

## Timing
- Reset values: s_ready = 1, ram_adr = 0, ram_data = 0, ram_write = 0, mode = 0, fft_start = 0, frame_err = 0, frame_cnt = 0.
- Write latency is 1 cycle: a beat accepted at edge t appears on the ram_* outputs during cycle t+1.
- A frame takes N accepted beats. In a back-to-back stream, the last beat is at cycle t, DRAIN at t+1 (carrying the last ram_write), and mode = 1 with fft_start at t+2.
- If fft_done arrives at cycle d, then s_ready = 1 from d+1.
- frame_err is asserted in the cycle after the offending beat, coincident with that beat's ram_write.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- FFT_LOADER_BITREV_EN defined: addr_map(idx) is the bit-reversal of idx over LOG2N bits, so the RAM is pre-ordered for an in-place decimation-in-time FFT.
- FFT_LOADER_BITREV_EN undefined: addr_map(idx) = idx, giving natural order. The FFT engine then performs the reordering itself.

## Structure
- Package fft_pkg holds:
  - the ADDR_W = 12 and DATA_W = 16 constants,
  - the typedef enum for loader_state_t {LOAD, DRAIN, COMPUTE},
  - shared with the RAM and the FFT control.
- Sub-module fft_bitrev is a combinational LOG2N-bit reverser, parameterised by LOG2N. It is instantiated only when FFT_LOADER_BITREV_EN is defined.

## Test plan
- Back-to-back frame, LOG2N = 4 with BITREV_EN, samples 0x0000..0x000F:
  - writes go to addresses 0, 8, 4, 12, 2, …, 15, with ram_data equal to the sample;
  - mode = 1 and fft_start pulse appear 2 cycles after the 16th beat;
  - frame_cnt = 1.
- Same stimulus with BITREV_EN undefined: ram_adr = 0..15 in order, and ram_data matches the sample.
- Early s_last on beat 5, LOG2N = 4:
  - frame_err pulses once;
  - 6 writes occur and mode stays 0;
  - the next 16 beats load a full frame starting at idx 0.
- Backpressure: s_valid held high through COMPUTE.
  - s_ready = 0 and there are no writes until fft_done.
  - With fft_done at cycle d, the first new write appears at d+2.
- Reset:
  - rst asserted after 7 beats gives all reset values immediately, with no further ram_write.
  - A full frame after release completes normally with frame_cnt = 1.
- fft_done pulsed while in LOAD or DRAIN: no effect on state, mode, or frame_cnt.
